// File: rtl/alu_seq.sv
// alu_seq: ALU with single-cycle logic/arith ops and iterative shift-add multiply / restoring divide.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [3:0]       ALUControlE,
  input  logic             ValidE,
  input  logic             FlushE,
  output logic             BusyE,
  output logic             ValidM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic             ZeroM
);
  localparam int CNTW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state, state_d;
  logic [CNTW-1:0]    cnt, cnt_d;
  logic [2*WIDTH-1:0] acc, acc_d, mul_nxt;
  logic [WIDTH:0]     rem, rem_d, sum, rem_nxt;
  logic [WIDTH+1:0]   diff;
  logic [WIDTH-1:0]   opa, opa_d, q_nxt, alu, fin, res_d;
  logic [1:0]         sel, sel_d;
  logic               eq, eq_d, zero_d, vld_d, accept, iter, div0, ge;
  // acc holds {product hi, multiplier} for MUL or {0, dividend->quotient} for DIV
  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
  assign mul_nxt = {sum, acc[WIDTH-1:1]};
  assign diff    = {rem, acc[WIDTH-1]} - {2'b00, opa};
  assign ge      = ~diff[WIDTH+1];
  assign rem_nxt = ge ? diff[WIDTH:0] : {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign q_nxt   = {acc[WIDTH-2:0], ge};
  assign fin     = sel[1] ? (sel[0] ? rem_nxt[WIDTH-1:0] : q_nxt)
                          : (sel[0] ? mul_nxt[2*WIDTH-1:WIDTH] : mul_nxt[WIDTH-1:0]);
  assign div0    = ALUControlE[1] && SrcBE == '0;
  assign iter    = ALUControlE[3:2] == 2'b10 && !div0;
  assign accept  = ValidE && state == IDLE && !FlushE;
  assign BusyE   = state == RUN;
  always_comb begin
    case (ALUControlE)
      4'd0:    alu = SrcAE + SrcBE;
      4'd1:    alu = SrcAE - SrcBE;
      4'd2:    alu = SrcAE & SrcBE;
      4'd3:    alu = SrcAE | SrcBE;
      4'd4:    alu = WIDTH'(SrcAE > SrcBE);
      4'd5:    alu = WIDTH'(SrcAE < SrcBE);
      4'd6:    alu = SrcAE ^ SrcBE;
      4'd7:    alu = WIDTH'(SrcAE == SrcBE);
      4'd10:   alu = '1;
      4'd11:   alu = SrcAE;
      default: alu = '0;
    endcase
  end
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    acc_d   = acc;
    rem_d   = rem;
    opa_d   = opa;
    sel_d   = sel;
    eq_d    = eq;
    res_d   = ALUResultM;
    zero_d  = ZeroM;
    vld_d   = 1'b0;
    if (FlushE) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state == RUN) begin
      cnt_d = cnt - CNTW'(1);
      acc_d = sel[1] ? {acc[2*WIDTH-1:WIDTH], q_nxt} : mul_nxt;
      rem_d = sel[1] ? rem_nxt : rem;
      if (cnt == CNTW'(1)) begin
        state_d = IDLE;
        res_d   = fin;
        zero_d  = eq;
        vld_d   = 1'b1;
      end
    end else if (accept) begin
      sel_d = ALUControlE[1:0];
      eq_d  = SrcAE == SrcBE;
      if (iter) begin
        state_d = RUN;
        cnt_d   = CNTW'(WIDTH);
        acc_d   = {{WIDTH{1'b0}}, ALUControlE[1] ? SrcAE : SrcBE};
        opa_d   = ALUControlE[1] ? SrcBE : SrcAE;
        rem_d   = '0;
      end else begin
        res_d  = alu;
        zero_d = SrcAE == SrcBE;
        vld_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      rem        <= '0;
      opa        <= '0;
      sel        <= '0;
      eq         <= 1'b0;
      ALUResultM <= '0;
      ZeroM      <= 1'b0;
      ValidM     <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      acc        <= acc_d;
      rem        <= rem_d;
      opa        <= opa_d;
      sel        <= sel_d;
      eq         <= eq_d;
      ALUResultM <= res_d;
      ZeroM      <= zero_d;
      ValidM     <= vld_d;
    end
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (min 4, even).
REQ-002 SHALL have localparam CNTW = clog2(WIDTH)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port SrcAE  input  WIDTH  operand A.
REQ-006 SHALL have port SrcBE  input  WIDTH  operand B.
REQ-007 SHALL have port ALUControlE  input  4  operation select.
REQ-008 SHALL have port ValidE  input  1  operation request.
REQ-009 SHALL have port FlushE  input  1  synchronous abort of any operation.
REQ-010 SHALL have port BusyE  output  1  registered; iterative op in progress, new requests ignored.
REQ-011 SHALL have port ValidM  output  1  registered one-cycle result strobe.
REQ-012 SHALL have port ALUResultM  output  WIDTH  registered result.
REQ-013 SHALL have port ZeroM  output  1  registered SrcAE==SrcBE of the accepted op.

Function
REQ-014 SHALL accept an op on a rising edge where ValidE=1, BusyE=0, FlushE=0; operands and ALUControlE are captured then.
REQ-015 SHALL implement single-cycle codes: 0 add, 1 sub, 2 and, 3 or, 4 unsigned A>B, 5 unsigned A<B, 6 xor, 7 A==B; compares zero-extended to WIDTH; add/sub wrap modulo 2^WIDTH.
REQ-016 SHALL implement iterative codes: 8 MUL (low WIDTH of unsigned product), 9 MULHU (high WIDTH), 10 DIVU quotient, 11 REMU remainder.
REQ-017 SHALL return 0 for codes 12-15 as single-cycle ops.
REQ-018 Single-cycle op accepted at edge N: ALUResultM, ZeroM updated and ValidM=1 after edge N; BusyE stays 0.
REQ-019 Iterative op: FSM IDLE -> RUN at edge N; BusyE=1 after edge N; one shift-add / restoring-subtract step per cycle; counter loads WIDTH, decrements per step.
REQ-020 On the edge where counter reaches 0 (edge N+WIDTH): RUN -> IDLE, BusyE=0, ALUResultM loaded, ValidM=1 for one cycle.
REQ-021 Divide by zero (codes 10/11, SrcBE=0): no RUN state; single-cycle; quotient all ones, remainder = SrcAE.
REQ-022 ValidM SHALL be 0 in every cycle not named in REQ-018/020/021; ALUResultM and ZeroM hold last value otherwise.
REQ-023 ValidE while BusyE=1 SHALL be ignored (no queueing, no state change).
REQ-024 Back-to-back accepts SHALL be possible: a request may be accepted on the same edge that completes an iterative op only if BusyE was 0 before that edge (i.e. never; BusyE=1 blocks it); single-cycle ops may be accepted every cycle.
REQ-025 FlushE=1 at any edge: FSM -> IDLE, BusyE=0, ValidM=0, counter cleared; ALUResultM unchanged; flush beats simultaneous ValidE and completion.
REQ-026 Multiplier SHALL hold 2*WIDTH partial product; divider SHALL hold WIDTH+1 partial remainder; no signed ops.

Reset
REQ-027 rst_n=0 SHALL asynchronously force FSM IDLE, counter 0, BusyE 0, ValidM 0, ALUResultM 0, ZeroM 0, internal operand/partial registers 0.
REQ-028 Reset mid-RUN SHALL abandon the op; no ValidM after release.
REQ-029 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 WIDTH=32: add 0xFFFFFFFF+1 -> ALUResultM 0, ValidM 1 cycle after accept, ZeroM 0; code 7 with 5,5 -> result 1, ZeroM 1.
REQ-031 MUL 0xFFFFFFFF*0xFFFFFFFF -> BusyE 1 for 32 cycles, then ValidM with 0x00000001; MULHU same operands -> 0xFFFFFFFE.
REQ-032 DIVU 100/7 -> 14 after 32 cycles; REMU -> 2; DIVU 9/0 -> 0xFFFFFFFF single-cycle; REMU 9/0 -> 9.
REQ-033 ValidE pulses during BusyE -> no extra ValidM, result of original op unchanged; FlushE at cycle 10 of MUL -> BusyE 0 next cycle, no ValidM, ALUResultM holds prior value.
REQ-034 rst_n low mid-DIVU -> all outputs 0 immediately without clock; after release, add 3+4 accepted on first edge -> 7.
REQ-035 WIDTH=8 regression: MUL 0xFF*0xFF -> 0x01 after 8 cycles; random ops vs reference model, 10k ops, with random ValidE/FlushE.
